util_axis_1553_encoder_buf: RTL and testbench

Parametrised MIL-STD-1553 Manchester II encoder with an input word buffer, selectable bit rate and per-word inter-word gap control. Accepts 16-bit words over AXI-Stream, frames each with a command/status or data sync and odd parity, and drives the bus transceiver through a differential pair with an enable. It sits between the message sequencer and the transceiver pins. It also sends back-to-back words as one contiguous message, which the single-register encoder cannot do.

---
 rtl/util_axis_1553_pkg.sv | 46 ++++
 rtl/util_axis_1553_word_fifo.sv | 70 +++++++
 rtl/util_axis_1553_encoder_buf.sv | 173 +++++++++++++++++
 tb/tb_util_axis_1553_encoder_buf.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_axis_1553_pkg.sv
// Shared types and constants for the MIL-STD-1553 Manchester II encoder.
// The word format is {tuser[7:0], tdata[15:0]}, as it sits in the input buffer.
package util_axis_1553_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } state_e;

  // Line symbols on {positive, negative} legs
  localparam logic [1:0] SYM_H   = 2'b10;
  localparam logic [1:0] SYM_L   = 2'b01;
  localparam logic [1:0] SYM_OFF = 2'b00;

  // Sync half-bit patterns, sent MSB first, 1 = H and 0 = L
  localparam logic [5:0] CMD_SYNC_PAT  = 6'b111000;
  localparam logic [5:0] DATA_SYNC_PAT = 6'b000111;

  // tuser field positions
  localparam int SYNC_SEL = 7;
  localparam int PAR_INV  = 6;
  localparam int GAP_MSB  = 3;
  localparam int GAP_LSB  = 0;

  localparam int TDATA_W = 16;
  localparam int TUSER_W = 8;
  localparam int WORD_W  = TDATA_W + TUSER_W;

  localparam int SYNC_HALF_BITS = 6;
  localparam int DATA_HALF_BITS = 32;
  localparam int PAR_HALF_BITS  = 2;
  localparam int WORD_HALF_BITS = SYNC_HALF_BITS + DATA_HALF_BITS + PAR_HALF_BITS;

  function automatic logic [1:0] half_sym(input logic level);
    return level ? SYM_H : SYM_L;
  endfunction

  // Manchester II: logic 1 is H then L, logic 0 is L then H
  function automatic logic [1:0] manch_sym(input logic bit_val, input logic second_half);
    return half_sym(bit_val ^ second_half);
  endfunction

endpackage

// File: rtl/util_axis_1553_word_fifo.sv
// Synchronous word buffer holding {tuser, tdata} ahead of the 1553 encoder.
// Flags are registered; full reads high during reset so upstream holds off.
module util_axis_1553_word_fifo
  import util_axis_1553_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(depth);

  logic [WORD_W-1:0] mem_q [depth];
  logic [WORD_W-1:0] mem_d [depth];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push, pop;

  always_comb begin
    push     = wr_en & ~full_q;
    pop      = rd_en & ~empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/util_axis_1553_encoder_buf.sv
// Buffered MIL-STD-1553 Manchester II encoder: AXI-Stream words in, framed
// differential bus symbols out. Define UTIL_AXIS_1553_ENC_BUF_ERR_INJ_EN to let
// tuser[6] invert the parity of a word for error injection.
//
// Handshake: a word transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high; tready is a registered "buffer not full" and
// never depends combinationally on tvalid.
module util_axis_1553_encoder_buf
  import util_axis_1553_pkg::*;
#(
  parameter int clock_speed = 20000000,
  parameter int bit_rate    = 1000000,
  parameter int fifo_depth  = 4
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [1:0]  diff,
  output logic        en_diff
);

  localparam int HB  = clock_speed / (2 * bit_rate);
  localparam int HBW = $clog2(HB + 1);

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [WORD_W-1:0] fifo_rdata;

  assign s_axis_tready = ~fifo_full;
  assign fifo_push     = s_axis_tvalid & s_axis_tready;

  util_axis_1553_word_fifo #(
    .depth(fifo_depth)
  ) u_fifo (
    .aclk   (aclk),
    .rst    (rst),
    .wr_en  (fifo_push),
    .wr_data({s_axis_tuser, s_axis_tdata}),
    .rd_en  (fifo_pop),
    .rd_data(fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  state_e            state_q, state_d;
  logic [HBW-1:0]    hb_q, hb_d;
  logic [5:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        diff_q, diff_d;
  logic              en_q, en_d;

  logic              hb_last;
  logic [5:0]        idx_last;
  logic [3:0]        gap;
  logic [15:0]       tdata_q;
  logic [5:0]        sync_pat;
  logic              par_bit;
  logic              unused_bits;

  assign gap      = word_q[TDATA_W+GAP_MSB:TDATA_W+GAP_LSB];
  assign tdata_q  = word_q[TDATA_W-1:0];
  assign sync_pat = word_q[TDATA_W+SYNC_SEL] ? CMD_SYNC_PAT : DATA_SYNC_PAT;
  assign hb_last  = (hb_q == HBW'(HB - 1));

`ifdef UTIL_AXIS_1553_ENC_BUF_ERR_INJ_EN
  assign par_bit     = ~^tdata_q ^ word_q[TDATA_W+PAR_INV];
  assign unused_bits = ^word_q[TDATA_W+5:TDATA_W+4];
`else
  assign par_bit     = ~^tdata_q;
  assign unused_bits = ^word_q[TDATA_W+PAR_INV:TDATA_W+4];
`endif

  // Index of the final half-bit of the current phase
  always_comb begin
    unique case (state_q)
      ST_SYNC:   idx_last = 6'(SYNC_HALF_BITS - 1);
      ST_DATA:   idx_last = 6'(DATA_HALF_BITS - 1);
      ST_PARITY: idx_last = 6'(PAR_HALF_BITS - 1);
      ST_GAP:    idx_last = {1'b0, gap, 1'b0} - 6'd1;
      default:   idx_last = '0;
    endcase
  end

  // Sequencer: the next word is popped on the last cycle of parity or gap,
  // so consecutive words leave the line with no dead cycles.
  always_comb begin
    state_d  = state_q;
    hb_d     = hb_q;
    idx_d    = idx_q;
    word_d   = word_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        hb_d  = '0;
        idx_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_rdata;
          state_d  = ST_SYNC;
        end
      end
      default: begin
        hb_d = hb_last ? '0 : hb_q + 1'b1;
        if (hb_last) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == idx_last) begin
            idx_d = '0;
            unique case (state_q)
              ST_SYNC: state_d = ST_DATA;
              ST_DATA: state_d = ST_PARITY;
              default: begin
                if (state_q == ST_PARITY && gap != 4'd0) begin
                  state_d = ST_GAP;
                end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  word_d   = fifo_rdata;
                  state_d  = ST_SYNC;
                end else begin
                  state_d = ST_IDLE;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  // Line symbol for the current half-bit, registered one cycle later
  always_comb begin
    diff_d = SYM_OFF;
    en_d   = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        en_d   = 1'b1;
        diff_d = half_sym(sync_pat[3'd5 - idx_q[2:0]]);
      end
      ST_DATA: begin
        en_d   = 1'b1;
        diff_d = manch_sym(tdata_q[~idx_q[4:1]], idx_q[0]);
      end
      ST_PARITY: begin
        en_d   = 1'b1;
        diff_d = manch_sym(par_bit, idx_q[0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hb_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      diff_q  <= SYM_OFF;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hb_q    <= hb_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      diff_q  <= diff_d;
      en_q    <= en_d;
    end
  end

  assign diff    = diff_q;
  assign en_diff = en_q;

endmodule

// File: tb/tb_util_axis_1553_encoder_buf.sv
// Scoreboard bench for util_axis_1553_encoder_buf: expected half-bit patterns
// are queued at each accepted transfer and a line monitor compares them.
module tb_util_axis_1553_encoder_buf;

  localparam int HB       = 10;
  localparam int WORD_CYC = 40 * HB;
  localparam int LIMIT    = 20000;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tuser = '0;
  logic        s_axis_tready;
  logic [1:0]  diff;
  logic        en_diff;

  util_axis_1553_encoder_buf #(
    .clock_speed(20000000),
    .bit_rate   (1000000),
    .fifo_depth (4)
  ) dut (
    .aclk         (aclk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .diff         (diff),
    .en_diff      (en_diff)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [39:0] exp_q[$];
  int          sent_cnt = 0;
  int          first_stall = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference half-bit pattern, MSB first, 1 = H and 0 = L
  function automatic logic [39:0] model(input logic [15:0] d, input logic [7:0] u);
    logic [39:0] p;
    logic        par;
    p[39:34] = u[7] ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 16; i++) p[33-2*i -: 2] = d[15-i] ? 2'b10 : 2'b01;
    par = ~^d;
`ifdef UTIL_AXIS_1553_ENC_BUF_ERR_INJ_EN
    par = par ^ u[6];
`endif
    p[1:0] = par ? 2'b10 : 2'b01;
    return p;
  endfunction

  // ---------------- monitor ----------------
  logic        mon_active = 1'b0;
  logic        mon_bad;
  logic [39:0] mon_exp, mon_got;
  int          mon_cyc;

  always @(negedge aclk) begin
    int          idx;
    logic [1:0]  sym;
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (en_diff) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
          mon_exp = '0;
        end else begin
          mon_exp = exp_q.pop_front();
        end
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_got    = '0;
        mon_bad    = 1'b0;
      end else begin
        check("idle_diff", diff, 2'b00);
      end
    end
    if (!rst && mon_active) begin
      idx = mon_cyc / HB;
      sym = mon_exp[39-idx] ? 2'b10 : 2'b01;
      if (!en_diff || diff !== sym) mon_bad = 1'b1;
      if (mon_cyc % HB == HB / 2) mon_got[39-idx] = (diff == 2'b10);
      mon_cyc++;
      if (mon_cyc == WORD_CYC) begin
        check("word_pattern", mon_got, mon_exp);
        check("word_exact_timing", mon_bad, 1'b0);
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] d, input logic [7:0] u, input logic [39:0] pat);
    int n;
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < LIMIT) begin
      if (first_stall < 0) first_stall = sent_cnt;
      @(negedge aclk);
      n++;
    end
    if (n >= LIMIT) fail_now("send_timeout");
    exp_q.push_back(pat);
    sent_cnt++;
    @(posedge aclk);
  endtask

  task automatic idle_input();
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_rise();
    int n = 0;
    while (!en_diff && n < LIMIT) begin
      @(negedge aclk);
      n++;
    end
    if (n >= LIMIT) fail_now("rise_timeout");
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (en_diff && n < LIMIT) begin
      n++;
      @(negedge aclk);
    end
  endtask

  task automatic count_low(output int n, output logic bad);
    n   = 0;
    bad = 1'b0;
    while (!en_diff && n < LIMIT) begin
      if (diff !== 2'b00) bad = 1'b1;
      n++;
      @(negedge aclk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || en_diff) && n < LIMIT) begin
      @(negedge aclk);
      n++;
    end
    if (n >= LIMIT) fail_now("drain_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic bad;

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge aclk);
    check("rst_diff", diff, 2'b00);
    check("rst_en_diff", en_diff, 1'b0);
    check("rst_tready", s_axis_tready, 1'b0);
    rst = 1'b0;
    @(negedge aclk);
    check("tready_after_rst", s_axis_tready, 1'b1);
    repeat (3) @(negedge aclk);

    // Command word of all ones: latency and enable width
    send(16'hFFFF, 8'h80, 40'hE2_AAAA_AAAA);
    idle_input();
    check("lat_after_edge_n", en_diff, 1'b0);
    @(negedge aclk);
    check("lat_after_edge_n1", en_diff, 1'b0);
    @(negedge aclk);
    check("lat_after_edge_n2_en", en_diff, 1'b1);
    check("lat_after_edge_n2_diff", diff, 2'b10);
    count_high(n);
    check("ffff_en_width", n, WORD_CYC);
    wait_idle();

    // Data word of all zeros
    send(16'h0000, 8'h00, 40'h1D_5555_5556);
    idle_input();
    wait_idle();

    // Three back-to-back words, no gap
    send(16'hA5C3, 8'h80, model(16'hA5C3, 8'h80));
    send(16'h1234, 8'h00, model(16'h1234, 8'h00));
    send(16'h8001, 8'h80, model(16'h8001, 8'h80));
    idle_input();
    wait_rise();
    count_high(n);
    check("b2b_en_width", n, 3 * WORD_CYC);
    wait_idle();

    // Two words with a 15-bit-time gap after each
    send(16'h7E81, 8'h8F, model(16'h7E81, 8'h8F));
    send(16'h0240, 8'h8F, model(16'h0240, 8'h8F));
    idle_input();
    wait_rise();
    count_high(n);
    check("gap_word1_width", n, WORD_CYC);
    count_low(n, bad);
    check("gap_width", n, 15 * 2 * HB);
    check("gap_diff_off", bad, 1'b0);
    count_high(n);
    check("gap_word2_width", n, WORD_CYC);
    wait_idle();
    repeat (WORD_CYC) @(negedge aclk);

    // Streaming with tvalid held high: backpressure and ordering
    sent_cnt    = 0;
    first_stall = -1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      logic [7:0]  u;
      d = 16'(16'h1111 * (i + 1));
      u = i[0] ? 8'h80 : 8'h00;
      send(d, u, model(d, u));
    end
    idle_input();
    check("stall_after_accepts", first_stall, 5);
    wait_idle();
    check("stream_all_sent", sent_cnt, 8);

    // Reset in the middle of a word with a second word buffered
    send(16'hC3C3, 8'h80, model(16'hC3C3, 8'h80));
    send(16'h0F0F, 8'h00, model(16'h0F0F, 8'h00));
    idle_input();
    wait_rise();
    repeat (20 * HB) @(negedge aclk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge aclk);
    check("midrst_diff", diff, 2'b00);
    check("midrst_en_diff", en_diff, 1'b0);
    check("midrst_tready", s_axis_tready, 1'b0);
    repeat (2) @(negedge aclk);
    rst = 1'b0;
    @(negedge aclk);
    check("midrst_tready_after", s_axis_tready, 1'b1);
    n = 0;
    repeat (3 * WORD_CYC / 2) begin
      @(negedge aclk);
      if (en_diff) n++;
    end
    check("no_residual_words", n, 0);

    // Recovery after reset
    send(16'h5A5A, 8'h80, model(16'h5A5A, 8'h80));
    idle_input();
    wait_idle();
    repeat (5) @(negedge aclk);
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
